// File: rtl/sar_adc_seq.sv
// Successive-approximation ADC sequencer.
// Scans the enabled channels of an analog mux. For each channel it runs
// 2^avg_log2 conversions and reports their truncated average. Each conversion
// is a track phase followed by a binary search on the DAC code, MSB first.
// The comparator is asynchronous, so it passes a two-flop synchroniser. Each
// bit trial samples the comparator in its last cycle, after the synchroniser
// has caught up with the code set at the start of that trial.
module sar_adc_seq #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int SAMPLE_CYC = 4,
    parameter int SETTLE_CYC = 3,
    localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CHANNELS-1:0] chan_mask,
    input  logic                continuous,
    input  logic [1:0]          avg_log2,
    input  logic                cmp_in,
    output logic                sample,
    output logic [CW-1:0]       mux_sel,
    output logic [WIDTH-1:0]    dac_code,
    output logic [WIDTH-1:0]    result,
    output logic [CW-1:0]       result_chan,
    output logic                result_valid,
    output logic                busy
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SAMPLE  = 3'd1,
        ST_CONVERT = 3'd2,
        ST_ACCUM   = 3'd3,
        ST_NEXT    = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] MID         = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [3:0]       SAMPLE_LAST = 4'(SAMPLE_CYC - 1);
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t                state_q, state_d;
    logic [CW-1:0]         chan_q, chan_d;
    logic [CHANNELS-1:0]   mask_q, mask_d;
    logic [1:0]            avg_q, avg_d;
    logic [WIDTH+2:0]      acc_q, acc_d;
    logic [3:0]            cyc_q, cyc_d;
    logic [3:0]            conv_q, conv_d;
    logic [WIDTH-1:0]      trial_q, trial_d;   // one-hot bit under trial
    logic [WIDTH-1:0]      code_q, code_d;
    logic                  sample_q, sample_d;
    logic                  busy_q, busy_d;
    logic [WIDTH-1:0]      result_q, result_d;
    logic [CW-1:0]         result_chan_q, result_chan_d;
    logic                  result_valid_q, result_valid_d;
    logic                  sync1_q, cmp_s_q;

    logic [CW:0]           nxt_s;
    logic [WIDTH+2:0]      sum_s;
    logic [WIDTH+2:0]      shifted_s;
    logic [WIDTH-1:0]      kept_s;

    // Index of the lowest set bit of a channel mask (0 when the mask is empty).
    function automatic logic [CW-1:0] lowest_chan(input logic [CHANNELS-1:0] m);
        logic [CW-1:0] idx;
        idx = {CW{1'b0}};
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (m[i]) idx = CW'(i);
            else      idx = idx;
        end
        return idx;
    endfunction

    // {found, index} of the lowest enabled channel strictly above cur.
    function automatic logic [CW:0] next_chan(input logic [CHANNELS-1:0] m,
                                              input logic [CW-1:0]       cur);
        logic          found;
        logic [CW-1:0] idx;
        found = 1'b0;
        idx   = {CW{1'b0}};
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) begin
                found = 1'b1;
                idx   = CW'(i);
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // Two-flop synchroniser for the asynchronous comparator output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            cmp_s_q <= 1'b0;
        end else begin
            sync1_q <= cmp_in;
            cmp_s_q <= sync1_q;
        end
    end

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d        = state_q;
        chan_d         = chan_q;
        mask_d         = mask_q;
        avg_d          = avg_q;
        acc_d          = acc_q;
        cyc_d          = cyc_q;
        conv_d         = conv_q;
        trial_d        = trial_q;
        code_d         = code_q;
        result_d       = result_q;
        result_chan_d  = result_chan_q;
        result_valid_d = 1'b0;
        nxt_s          = next_chan(mask_q, chan_q);
        sum_s          = acc_q + {3'b000, code_q};
        shifted_s      = sum_s >> avg_q;
        kept_s         = cmp_s_q ? code_q : (code_q & ~trial_q);

        case (state_q)
            ST_IDLE: begin
                if (start && (|chan_mask)) begin
                    state_d = ST_SAMPLE;
                    mask_d  = chan_mask;
                    avg_d   = avg_log2;
                    chan_d  = lowest_chan(chan_mask);
                    acc_d   = {(WIDTH+3){1'b0}};
                    conv_d  = 4'd0;
                    cyc_d   = 4'd0;
                    code_d  = MID;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SAMPLE: begin
                if (cyc_q == SAMPLE_LAST) begin
                    state_d = ST_CONVERT;
                    cyc_d   = 4'd0;
                    trial_d = MID;
                    code_d  = MID;
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end
            ST_CONVERT: begin
                if (cyc_q == SETTLE_LAST) begin
                    if (trial_q[0]) begin
                        state_d = ST_ACCUM;
                        code_d  = kept_s;
                    end else begin
                        trial_d = trial_q >> 1;
                        code_d  = kept_s | (trial_q >> 1);
                        cyc_d   = 4'd0;
                    end
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end
            ST_ACCUM: begin
                if ((conv_q + 4'd1) < (4'd1 << avg_q)) begin
                    state_d = ST_SAMPLE;
                    acc_d   = sum_s;
                    conv_d  = conv_q + 4'd1;
                    cyc_d   = 4'd0;
                    code_d  = MID;
                end else begin
                    // Result is published on the way into NEXT so that
                    // result_valid is high during the NEXT cycle.
                    state_d        = ST_NEXT;
                    acc_d          = {(WIDTH+3){1'b0}};
                    conv_d         = 4'd0;
                    result_d       = shifted_s[WIDTH-1:0];
                    result_chan_d  = chan_q;
                    result_valid_d = 1'b1;
                end
            end
            ST_NEXT: begin
                if (nxt_s[CW]) begin
                    state_d = ST_SAMPLE;
                    chan_d  = nxt_s[CW-1:0];
                    cyc_d   = 4'd0;
                    code_d  = MID;
                end else if (continuous) begin
                    if (start && (|chan_mask)) begin
                        mask_d = chan_mask;
                        avg_d  = avg_log2;
                        chan_d = lowest_chan(chan_mask);
                    end else begin
                        chan_d = lowest_chan(mask_q);
                    end
                    state_d = ST_SAMPLE;
                    cyc_d   = 4'd0;
                    code_d  = MID;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        sample_d = (state_d == ST_SAMPLE);
        busy_d   = (state_d != ST_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            chan_q         <= {CW{1'b0}};
            mask_q         <= {CHANNELS{1'b0}};
            avg_q          <= 2'd0;
            acc_q          <= {(WIDTH+3){1'b0}};
            cyc_q          <= 4'd0;
            conv_q         <= 4'd0;
            trial_q        <= {WIDTH{1'b0}};
            code_q         <= {WIDTH{1'b0}};
            sample_q       <= 1'b0;
            busy_q         <= 1'b0;
            result_q       <= {WIDTH{1'b0}};
            result_chan_q  <= {CW{1'b0}};
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            chan_q         <= chan_d;
            mask_q         <= mask_d;
            avg_q          <= avg_d;
            acc_q          <= acc_d;
            cyc_q          <= cyc_d;
            conv_q         <= conv_d;
            trial_q        <= trial_d;
            code_q         <= code_d;
            sample_q       <= sample_d;
            busy_q         <= busy_d;
            result_q       <= result_d;
            result_chan_q  <= result_chan_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign sample       = sample_q;
    assign mux_sel      = chan_q;
    assign dac_code     = code_q;
    assign result       = result_q;
    assign result_chan  = result_chan_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_sar_adc_seq.sv
// Scoreboard bench for sar_adc_seq. An ideal comparator drives cmp_in
// from a per-channel analog input. The input alternates between two values
// on successive conversions. The reference model predicts each averaged result
// as the plain arithmetic mean (truncated) of the inputs the conversions see.
module tb_sar_adc_seq;

    localparam int WIDTH      = 8;
    localparam int CHANNELS   = 4;
    localparam int SAMPLE_CYC = 4;
    localparam int SETTLE_CYC = 3;
    localparam int CW         = 2;
    localparam int LAT        = SAMPLE_CYC + WIDTH * SETTLE_CYC + 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [CHANNELS-1:0] chan_mask;
    logic                continuous;
    logic [1:0]          avg_log2;
    logic                cmp_in;
    logic                sample;
    logic [CW-1:0]       mux_sel;
    logic [WIDTH-1:0]    dac_code;
    logic [WIDTH-1:0]    result;
    logic [CW-1:0]       result_chan;
    logic                result_valid;
    logic                busy;

    sar_adc_seq #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS),
        .SAMPLE_CYC(SAMPLE_CYC), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .chan_mask(chan_mask),
        .continuous(continuous), .avg_log2(avg_log2), .cmp_in(cmp_in),
        .sample(sample), .mux_sel(mux_sel), .dac_code(dac_code),
        .result(result), .result_chan(result_chan),
        .result_valid(result_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int chan;
        int value;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   vin_a[CHANNELS];
    int   vin_b[CHANNELS];
    int   gconv       = 0;   // conversions started so far (environment view)
    int   model_g     = 0;   // conversion counter used by the reference model
    logic samp_prev   = 1'b0;
    logic busy_prev   = 1'b0;
    int   cyc         = 0;
    int   exit_cyc    = 0;
    int   samp_run    = 0;
    logic lat_check_en = 1'b0;

    // Analog environment: ideal comparator against the selected input.
    assign cmp_in = ((gconv[0] ? vin_b[mux_sel] : vin_a[mux_sel]) >= int'(dac_code));

    // Count conversions: a new one begins on every rising edge of sample.
    always @(negedge clk) begin
        if (sample && !samp_prev) gconv = gconv + 1;
        samp_prev = sample;
    end

    // Monitor: pops the scoreboard on every result and checks track length and latency.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            samp_run  = 0;
            busy_prev = 1'b0;
        end else begin
            if (busy && !busy_prev) exit_cyc = cyc;
            busy_prev = busy;
            if (sample) begin
                samp_run = samp_run + 1;
            end else if (samp_run != 0) begin
                vectors = vectors + 1;
                if (samp_run != SAMPLE_CYC) begin
                    miscompares = miscompares + 1;
                    $display("FAIL track_len got=%0d want=%0d", samp_run, SAMPLE_CYC);
                end
                samp_run = 0;
            end
            if (result_valid) begin
                vectors = vectors + 1;
                if (exp_q.size() == 0) begin
                    miscompares = miscompares + 1;
                    $display("FAIL unexpected_result chan=%0d value=%0h want=none",
                             result_chan, result);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (int'(result_chan) != e.chan || int'(result) != e.value) begin
                        miscompares = miscompares + 1;
                        $display("FAIL result got chan=%0d value=%0h want chan=%0d value=%0h",
                                 result_chan, result, e.chan, e.value);
                    end
                end
                if (lat_check_en) begin
                    lat_check_en = 1'b0;
                    vectors = vectors + 1;
                    if (cyc - exit_cyc != LAT) begin
                        miscompares = miscompares + 1;
                        $display("FAIL latency got=%0d want=%0d", cyc - exit_cyc, LAT);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        vectors = vectors + 1;
        if (got != want) begin
            miscompares = miscompares + 1;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_sample"}, int'(sample), 0);
        check({name, "_mux_sel"}, int'(mux_sel), 0);
        check({name, "_dac_code"}, int'(dac_code), 0);
        check({name, "_result"}, int'(result), 0);
        check({name, "_result_chan"}, int'(result_chan), 0);
        check({name, "_result_valid"}, int'(result_valid), 0);
        check({name, "_busy"}, int'(busy), 0);
    endtask

    // Reference model: one scan, each enabled channel in ascending order,
    // averaging 2^avg successive conversions.
    task automatic push_scan(input logic [CHANNELS-1:0] mask, input int avg);
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (mask[ch]) begin
                int   sum;
                exp_t e;
                sum = 0;
                for (int n = 0; n < (1 << avg); n++) begin
                    model_g = model_g + 1;
                    sum = sum + (model_g[0] ? vin_b[ch] : vin_a[ch]);
                end
                e.chan  = ch;
                e.value = sum >> avg;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic issue(input logic [CHANNELS-1:0] mask, input int avg,
                         input logic cont, input int nscans);
        int n;
        start      = 1'b1;
        chan_mask  = mask;
        avg_log2   = 2'(avg);
        continuous = cont;
        model_g    = gconv;
        for (int s = 0; s < nscans; s++) push_scan(mask, avg);
        n = 0;
        while (!busy && n < 5) begin
            tick();
            n++;
        end
        check("busy_after_start", int'(busy), 1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) begin
            miscompares = miscompares + 1;
            $display("FAIL timeout pending=%0d busy=%0d", exp_q.size(), busy);
        end
        check("idle_after_scan", int'(busy), 0);
    endtask

    initial begin
        int   n;
        logic busy_seen;
        rst        = 1'b1;
        start      = 1'b0;
        chan_mask  = 4'b0000;
        continuous = 1'b0;
        avg_log2   = 2'd0;
        for (int i = 0; i < CHANNELS; i++) begin
            vin_a[i] = 0;
            vin_b[i] = 0;
        end
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Single channel, no averaging, latency check.
        vin_a[0] = 'hA5;
        vin_b[0] = 'hA5;
        lat_check_en = 1'b1;
        issue(4'b0001, 0, 1'b0, 1);
        wait_done(200);

        // Two sparse channels at the code extremes.
        vin_a[1] = 'h10; vin_b[1] = 'h10;
        vin_a[3] = 'hFF; vin_b[3] = 'hFF;
        issue(4'b1010, 0, 1'b0, 1);
        wait_done(300);

        // Averaging of four alternating conversions.
        vin_a[0] = 'h40; vin_b[0] = 'h43;
        vin_a[1] = 'h40; vin_b[1] = 'h43;
        issue(4'b0011, 2, 1'b0, 1);
        wait_done(600);

        // Empty mask: start must be ignored.
        start     = 1'b1;
        chan_mask = 4'b0000;
        busy_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy || result_valid) busy_seen = 1'b1;
        end
        start = 1'b0;
        check("empty_mask_busy", int'(busy_seen), 0);

        // start while busy: new mask/avg must not take effect.
        vin_a[1] = int'($urandom_range(0, 255)); vin_b[1] = int'($urandom_range(0, 255));
        vin_a[2] = int'($urandom_range(0, 255)); vin_b[2] = int'($urandom_range(0, 255));
        issue(4'b0110, 1, 1'b0, 1);
        for (int i = 0; i < 40; i++) tick();
        start     = 1'b1;
        chan_mask = 4'b1001;
        avg_log2  = 2'd3;
        tick(); tick(); tick();
        start = 1'b0;
        wait_done(600);

        // Continuous scanning, stopped during the second scan's ch0 conversion.
        vin_a[0] = int'($urandom_range(0, 255)); vin_b[0] = int'($urandom_range(0, 255));
        vin_a[2] = int'($urandom_range(0, 255)); vin_b[2] = int'($urandom_range(0, 255));
        issue(4'b0101, 0, 1'b1, 2);
        n = 0;
        while (exp_q.size() > 2 && n < 300) begin
            tick();
            n++;
        end
        for (int i = 0; i < 10; i++) tick();
        continuous = 1'b0;
        wait_done(300);
        for (int i = 0; i < 5; i++) tick();
        check("cont_stopped_busy", int'(busy), 0);

        // Reset in the middle of CONVERT, then a fresh conversion.
        vin_a[2] = 'h5A; vin_b[2] = 'h5A;
        issue(4'b0100, 0, 1'b0, 0);
        for (int i = 0; i < 15; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 60; i++) tick();
        check("after_abort_busy", int'(busy), 0);
        issue(4'b0100, 0, 1'b0, 1);
        wait_done(200);

        // Randomized scans.
        for (int it = 0; it < 6; it++) begin
            logic [CHANNELS-1:0] m;
            int                  a;
            m = 4'($urandom_range(1, 15));
            a = int'($urandom_range(0, 3));
            for (int ch = 0; ch < CHANNELS; ch++) begin
                vin_a[ch] = int'($urandom_range(0, 255));
                vin_b[ch] = int'($urandom_range(0, 255));
            end
            issue(m, a, 1'b0, 1);
            wait_done(3000);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sar_adc_seq.md
SAR_ADC_SEQ -- requirements
Module: sar_adc_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: conversion resolution in bits, range 4..12.
REQ-002 SHALL have parameter CHANNELS, default 4: analog mux channel count, range 2..8; CW = clog2(CHANNELS).
REQ-003 SHALL have parameter SAMPLE_CYC, default 4: track cycles per conversion, range 1..15.
REQ-004 SHALL have parameter SETTLE_CYC, default 3: cycles per bit trial, range 3..15.
REQ-005 SHALL have ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  level; sampled in IDLE only.
- chan_mask  in  CHANNELS  channel enables; sampled at start.
- continuous  in  1  rescan enable; sampled at each scan end.
- avg_log2  in  2  averaging exponent, 1/2/4/8 conversions; sampled at start.
- cmp_in  in  1  asynchronous comparator output; 1 = Vin >= Vdac.
- sample  out  1  track/hold control; 1 = track.
- mux_sel  out  CW  analog mux select.
- dac_code  out  WIDTH  trial DAC code.
- result  out  WIDTH  averaged result; held until next update.
- result_chan  out  CW  channel of result.
- result_valid  out  1  one-cycle pulse per result.
- busy  out  1  high while not in IDLE.
REQ-006 All I/O SHALL be on clk; cmp_in SHALL pass a 2-flop synchroniser (cmp_s) before use.

Function
REQ-007 FSM states SHALL be IDLE, SAMPLE, CONVERT, ACCUM, NEXT.
REQ-008 IDLE->SAMPLE SHALL occur when start=1 and chan_mask!=0; the first channel is the lowest set bit of chan_mask. The latched mask, avg_log2, and a zeroed accumulator are taken at this transition.
REQ-009 With start=1 and chan_mask=0, the block SHALL stay in IDLE: busy=0, no result_valid.
REQ-010 SAMPLE SHALL last exactly SAMPLE_CYC cycles with sample=1. mux_sel SHALL equal the current channel, and dac_code SHALL equal the midscale 1<<(WIDTH-1).
REQ-011 CONVERT SHALL run WIDTH bit trials, MSB first, each SETTLE_CYC cycles, with sample=0 throughout.
REQ-012 At the start of trial k, the trial bit SHALL be set in dac_code.
REQ-013 In the last cycle of each trial, cmp_s SHALL be read: 0 clears the trial bit, 1 keeps it.
REQ-014 ACCUM SHALL last 1 cycle and add the final code to an accumulator of WIDTH+3 bits, which cannot overflow.
REQ-015 ACCUM SHALL then go to SAMPLE if fewer than 2^avg_log2 conversions are done for the channel, else to NEXT.
REQ-016 NEXT SHALL last 1 cycle and perform all of the following:
- set result = accumulator >> avg_log2, truncating;
- set result_chan to the current channel;
- pulse result_valid;
- clear the accumulator.
REQ-017 From NEXT, the block SHALL go to SAMPLE on the next higher enabled channel if one exists.
REQ-018 At scan end with continuous=1, the block SHALL wrap to the lowest enabled channel. If start=1 at that point, a new mask and avg_log2 SHALL be latched first.
REQ-019 At scan end with continuous=0, the block SHALL go to IDLE.
REQ-020 Single-conversion latency SHALL be SAMPLE_CYC + WIDTH*SETTLE_CYC + 1 cycles per averaged sample. result_valid SHALL assert one cycle after the final ACCUM.
REQ-021 start while busy SHALL be ignored. Clearing continuous mid-scan SHALL let the current scan complete.
REQ-022 chan_mask and avg_log2 changes while busy SHALL have no effect until the next latch point.

Reset
REQ-023 rst=1 SHALL immediately force:
- state to IDLE;
- sample=0, mux_sel=0, dac_code=0;
- result=0, result_chan=0, result_valid=0, busy=0;
- accumulator and synchroniser to 0.
REQ-024 Reset mid-conversion SHALL abort with no result_valid. The first start after reset release SHALL behave as a fresh start.

Verification
REQ-025 Defaults, model cmp_in = (Vin >= dac_code) with Vin=0xA5, mask=0001, avg=0, single scan -> one result_valid with result=0xA5, result_chan=0, 29 cycles after the IDLE exit; busy then 0.
REQ-026 mask=1010, Vin per channel {ch1=0x10, ch3=0xFF}, continuous=0 -> exactly two results in order (ch1, 0x10) then (ch3, 0xFF); sample=1 for exactly 4 cycles before each conversion.
REQ-027 avg_log2=2, Vin alternating 0x40/0x43 per conversion -> one result per channel after 4 conversions, value (0x40+0x43+0x40+0x43)>>2 = 0x41.
REQ-028 continuous=1, mask=0101 -> results ch0, ch2, ch0, ch2...; clear continuous during the ch0 conversion -> ch0 and ch2 complete, then IDLE.
REQ-029 chan_mask=0 with start=1 -> busy stays 0 and no result_valid. start pulse while busy -> ignored.
REQ-030 rst asserted mid-CONVERT -> all outputs at reset values in the same cycle, no result_valid. Restart after release gives a correct result.
